mb8_responder: RTL



---
 rtl/mb8_responder_pkg.sv | 19 +
 rtl/mb8_lane.sv | 32 +++
 rtl/mb8_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mb8_responder_pkg.sv
// Shared definitions for the mb8 byte-bus responder.
// Holds the default widths, derived lane/word-address constants and the
// responder state encoding.
package mb8_responder_pkg;

  localparam int unsigned MB8_DSZ = 8;             // byte data width
  localparam int unsigned MB8_ASZ = 17;            // byte address width (128K)
  localparam int unsigned MB8_WSZ = 32;            // RAM word width
  localparam int unsigned LANES   = MB8_WSZ / MB8_DSZ;
  localparam int unsigned WASZ    = MB8_ASZ - 2;   // RAM word address width

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RDW,
    WR
  } mb8_resp_st;

endpackage

// File: rtl/mb8_lane.sv
// Combinational byte-lane helper (little-endian, lane 0 = bits [DSZ-1:0]).
//   word_i : source word
//   lane_i : byte lane select
//   byte_i : byte to insert into the selected lane
//   byte_o : byte extracted from the selected lane of word_i
//   word_o : word_i with the selected lane replaced by byte_i
module mb8_lane
  import mb8_responder_pkg::*;
#(
  parameter int unsigned DSZ = MB8_DSZ,
  parameter int unsigned WSZ = MB8_WSZ,
  parameter int unsigned LW  = 2
) (
  input  logic [WSZ-1:0] word_i,
  input  logic [LW-1:0]  lane_i,
  input  logic [DSZ-1:0] byte_i,
  output logic [DSZ-1:0] byte_o,
  output logic [WSZ-1:0] word_o
);

  always_comb begin
    byte_o = '0;
    word_o = word_i;
    for (int unsigned i = 0; i < WSZ / DSZ; i++) begin
      if (lane_i == LW'(i)) begin
        byte_o                  = word_i[i*DSZ +: DSZ];
        word_o[i*DSZ +: DSZ]    = byte_i;
      end
    end
  end

endmodule

// File: rtl/mb8_responder.sv
// Responder (slave) end of the 8-bit memory-block bus. Serves byte reads and
// writes from a word-wide synchronous single-port RAM through a one-word
// cache; byte writes are read-modify-write on the RAM word.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req/we/ai/vi    : request, write enable, byte address, write byte
//   vo/ack          : read byte, one-cycle completion pulse
//   inv             : cache invalidate (RAM written by another agent)
//   ram_re/ram_we   : RAM read / write strobes
//   ram_a/ram_d     : RAM word address / write word
//   ram_q           : RAM read word, valid the cycle after ram_re
module mb8_responder
  import mb8_responder_pkg::*;
#(
  parameter int unsigned DSZ = MB8_DSZ,
  parameter int unsigned ASZ = MB8_ASZ,
  parameter int unsigned WSZ = MB8_WSZ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [ASZ-1:0]   ai,
  input  logic [DSZ-1:0]   vi,
  output logic [DSZ-1:0]   vo,
  output logic             ack,
  input  logic             inv,
  output logic             ram_re,
  output logic             ram_we,
  output logic [ASZ-3:0]   ram_a,
  output logic [WSZ-1:0]   ram_d,
  input  logic [WSZ-1:0]   ram_q
);

  mb8_resp_st     st_q, st_d;
  logic           ack_q, ack_d;
  logic [DSZ-1:0] vo_q, vo_d;
  logic           valid_q, valid_d;
  logic [ASZ-3:0] tag_q, tag_d;
  logic [WSZ-1:0] cache_q, cache_d;
  logic [ASZ-1:0] a_q, a_d;
  logic           we_q, we_d;
  logic [DSZ-1:0] vi_q, vi_d;
  logic [WSZ-1:0] m_q, m_d;

  logic           hit;
  logic [DSZ-1:0] cache_byte, ram_byte;
  logic [WSZ-1:0] cache_merged, ram_merged;

  // Hit is judged on the live address: only used in IDLE at accept time.
  assign hit = valid_q && (tag_q == ai[ASZ-1:2]) && !inv;

  mb8_lane #(.DSZ(DSZ), .WSZ(WSZ), .LW(2)) u_cache_lane (
    .word_i (cache_q),
    .lane_i (ai[1:0]),
    .byte_i (vi),
    .byte_o (cache_byte),
    .word_o (cache_merged)
  );

  mb8_lane #(.DSZ(DSZ), .WSZ(WSZ), .LW(2)) u_ram_lane (
    .word_i (ram_q),
    .lane_i (a_q[1:0]),
    .byte_i (vi_q),
    .byte_o (ram_byte),
    .word_o (ram_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      ack_q   <= 1'b0;
      vo_q    <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      cache_q <= '0;
      a_q     <= '0;
      we_q    <= 1'b0;
      vi_q    <= '0;
      m_q     <= '0;
    end else begin
      st_q    <= st_d;
      ack_q   <= ack_d;
      vo_q    <= vo_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cache_q <= cache_d;
      a_q     <= a_d;
      we_q    <= we_d;
      vi_q    <= vi_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    ack_d   = 1'b0;
    vo_d    = vo_q;
    valid_d = valid_q && !inv;
    tag_d   = tag_q;
    cache_d = cache_q;
    a_d     = a_q;
    we_d    = we_q;
    vi_d    = vi_q;
    m_d     = m_q;
    ram_re  = 1'b0;
    ram_we  = 1'b0;
    ram_a   = '0;
    ram_d   = '0;

    unique case (st_q)
      IDLE: begin
        // ack_q guard keeps a req still held in the ack cycle from re-accepting.
        if (req && !ack_q) begin
          a_d  = ai;
          we_d = we;
          vi_d = vi;
          if (hit && !we) begin
            vo_d  = cache_byte;
            ack_d = 1'b1;
          end else if (hit) begin
            m_d  = cache_merged;
            st_d = WR;
          end else begin
            st_d = RD;
          end
        end
      end
      RD: begin
        ram_re = 1'b1;
        ram_a  = a_q[ASZ-1:2];
        st_d   = RDW;
      end
      RDW: begin
        // Refill wins over a concurrent inv: the word was just read.
        cache_d = ram_q;
        tag_d   = a_q[ASZ-1:2];
        valid_d = 1'b1;
        if (!we_q) begin
          vo_d  = ram_byte;
          ack_d = 1'b1;
          st_d  = IDLE;
        end else begin
          m_d  = ram_merged;
          st_d = WR;
        end
      end
      WR: begin
        ram_we  = 1'b1;
        ram_a   = a_q[ASZ-1:2];
        ram_d   = m_q;
        cache_d = m_q;
        tag_d   = a_q[ASZ-1:2];
        valid_d = 1'b1;
        ack_d   = 1'b1;
        st_d    = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign vo  = vo_q;
  assign ack = ack_q;

endmodule
